// File: rtl/bus_stop_uart_tx.sv
// Bus-stop station controller: debounces call/cancel/arrival inputs, tracks the pickup request
// and sends one ASCII command byte per accepted event as an 8N1 UART frame.
module bus_stop_uart_tx #(
  parameter int unsigned CLOCKS_PER_BIT = 5208,
  parameter int unsigned DEBOUNCE_CLKS  = 500000,
  parameter logic [7:0]  CODE_CANCEL    = 8'h41,
  parameter logic [7:0]  CODE_CALL      = 8'h42,
  parameter logic [7:0]  CODE_ARRIVE    = 8'h45
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_call,
  input  logic btn_cancel,
  input  logic bus_arrive,
  output logic uart_txd,
  output logic tx_busy,
  output logic req_led
);

  localparam int unsigned DbW  = $clog2(DEBOUNCE_CLKS + 1);
  localparam int unsigned BitW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CLKS - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(CLOCKS_PER_BIT - 1);

  // Input index: 0 = call, 1 = cancel, 2 = arrive.
  localparam int unsigned InCall   = 0;
  localparam int unsigned InCancel = 1;
  localparam int unsigned InArrive = 2;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

  logic [2:0]            raw;
  logic [2:0]            meta_q, sync_q;
  logic [2:0]            deb_q, deb_d;
  logic [2:0]            evt_q, evt_d;
  logic [2:0][DbW-1:0]   db_cnt_q, db_cnt_d;

  logic                  req_q, req_d;
  logic                  slot_wr;
  logic [7:0]            slot_wr_byte;
  logic                  slot_full_q, slot_full_d;
  logic [7:0]            slot_q, slot_d;

  tx_state_e             state_q, state_d;
  logic [BitW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  txd_q, txd_d;
  logic                  bit_done;

  assign raw = {bus_arrive, btn_cancel, btn_call};

  // Two-flop synchronisers for the asynchronous inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
    end
  end

  // Debounce: the counter only runs while the synchronised level disagrees with the accepted one.
  always_comb begin
    deb_d    = deb_q;
    evt_d    = '0;
    db_cnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          deb_d[i] = sync_q[i];
          evt_d[i] = sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q    <= '0;
      evt_q    <= '0;
      db_cnt_q <= '0;
    end else begin
      deb_q    <= deb_d;
      evt_q    <= evt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // Request tracking: only the highest-priority event of a cycle is considered.
  always_comb begin
    req_d        = req_q;
    slot_wr      = 1'b0;
    slot_wr_byte = CODE_CALL;
    if (evt_q[InCancel]) begin
      if (req_q) begin
        req_d        = 1'b0;
        slot_wr      = 1'b1;
        slot_wr_byte = CODE_CANCEL;
      end
    end else if (evt_q[InArrive]) begin
      if (req_q) begin
        req_d        = 1'b0;
        slot_wr      = 1'b1;
        slot_wr_byte = CODE_ARRIVE;
      end
    end else if (evt_q[InCall]) begin
      if (!req_q) begin
        req_d        = 1'b1;
        slot_wr      = 1'b1;
        slot_wr_byte = CODE_CALL;
      end
    end
  end

  assign bit_done = (bit_cnt_q == BitLast);

  // TX next-state; a slot write in the same cycle as an IDLE load refills the slot.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    slot_full_d = slot_full_q;
    slot_d      = slot_q;
    txd_d       = 1'b1;

    if (state_q != StIdle) begin
      bit_cnt_d = bit_done ? '0 : bit_cnt_q + BitW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (slot_full_q) begin
          shift_d     = slot_q;
          slot_full_d = 1'b0;
          bit_cnt_d   = '0;
          state_d     = StStart;
        end
      end
      StStart: begin
        if (bit_done) begin
          bit_idx_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_done) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (bit_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (slot_wr) begin
      slot_full_d = 1'b1;
      slot_d      = slot_wr_byte;
    end

    // Line level is registered from the next state so uart_txd is glitch-free.
    case (state_d)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q       <= 1'b0;
      slot_full_q <= 1'b0;
      slot_q      <= '0;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      txd_q       <= 1'b1;
    end else begin
      req_q       <= req_d;
      slot_full_q <= slot_full_d;
      slot_q      <= slot_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      txd_q       <= txd_d;
    end
  end

  assign uart_txd = txd_q;
  assign tx_busy  = (state_q != StIdle);
  assign req_led  = req_q;

endmodule
